serial_link_sched: RTL and testbench
====================================

Name: serial_link_sched

Overview:
- Hardware scheduler that drains the two scanner buffer channels onto the single serial_out link without CPU involvement.
- Arbitrates round-robin between channel 0 and channel 1 burst requests.
- Frames each burst as one header byte followed by N payload bytes.
- Drives the serial_out load/transmit-enable handshake and pops the granted buffer after each byte completes.

Parameters:
- DATA_W, 8, serial character / buffer data width.
- LEN_W, 4, burst length field width; burst length = len+1, so 1..16 bytes.
- TO_W, 20, width of the per-character timeout counter.
- TIMEOUT_CYC, 1000000, cycles to wait for char_sent before aborting the burst.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset. One clock; reset is asynchronous and active-low.
- req0 / req1, in, 1: level burst request from channel 0 / 1. Held until the matching done pulse.
- len0 / len1, in, LEN_W: burst length minus 1, sampled at grant.
- data0 / data1, in, DATA_W: head-of-buffer byte. Valid while req is high; updates the cycle after read_inc.
- read_inc0 / read_inc1, out, 1: one-cycle pop strobe to the buffer.
- done0 / done1, out, 1: one-cycle burst-complete strobe.
- ser_data, out, DATA_W: parallel byte to serial_out.
- ser_load, out, 1: one-cycle load strobe; ser_data is valid in that cycle.
- ser_trans_en, out, 1: transmit enable. High from the ser_load cycle until char_sent.
- char_sent, in, 1: one-cycle strobe from serial_out when a character has finished shifting.
- busy, out, 1: high in every state except IDLE.
- grant, out, 1: currently granted channel. Holds its last value when idle.
- timeout_err, out, 1: sticky abort flag.
- clear_err, in, 1: synchronous clear of timeout_err.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, last_grant=1 so channel 0 wins the first tie.
  - grant=0, timeout_err=0.
  - All strobes, ser_trans_en, busy, ser_data and the counters are 0.
- Header byte = {3'b101, grant, len_latched}.
- States: IDLE, HDR_LOAD, HDR_WAIT, DAT_LOAD, DAT_WAIT, POP, DONE, ERR.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant that channel.
  - If both are high, grant ~last_grant.
  - On a grant: latch len, set remaining=len, go to HDR_LOAD.
- HDR_LOAD (one cycle): ser_data=header, ser_load=1, ser_trans_en=1, timeout counter cleared → HDR_WAIT.
- HDR_WAIT:
  - ser_trans_en=1 and the counter increments each cycle.
  - char_sent → DAT_LOAD.
  - Counter reaching TIMEOUT_CYC-1 with no char_sent → ERR.
- DAT_LOAD (one cycle): ser_data=data[grant], ser_load=1, ser_trans_en=1, counter cleared → DAT_WAIT.
- DAT_WAIT: same rules as HDR_WAIT; char_sent → POP.
- POP (one cycle):
  - read_inc[grant]=1.
  - If remaining==0 → DONE; otherwise remaining-=1 → DAT_LOAD.
  - The one-cycle gap lets the buffer present its new head.
- DONE (one cycle): done[grant]=1, last_grant=grant → IDLE.
- ERR (one cycle): timeout_err set, ser_trans_en=0, no done and no read_inc → IDLE. The burst is abandoned.
- timeout_err:
  - Stays set until clear_err=1.
  - If set and clear occur in the same cycle, set wins.
  - Its value does not block new grants.
- Latency:
  - A request seen in IDLE at cycle t gives ser_load at t+1.
  - The gap from char_sent to the next ser_load is 1 cycle after the header and 2 cycles between payload bytes (POP + DAT_LOAD).
- Boundary and corner cases:
  - char_sent outside HDR_WAIT / DAT_WAIT is ignored.
  - req dropped mid-burst is ignored; the burst completes for the full latched length.
  - len/data changes after the grant have no effect on length.
  - req still high in the IDLE cycle after DONE is a new request, and round-robin applies.
  - char_sent in the same cycle the counter hits its limit counts as success.
  - Reset mid-burst aborts immediately, with no done and no further read_inc.
- Width rules: the counters saturate by construction, and remaining never underflows because POP checks for zero first.

Decomposition:
- Shared package: state enum, HDR_SYNC=3'b101 constant, header-assembly function, and the DATA_W / LEN_W defaults.
- One sub-module: rr_arb2 (combinational pick of next grant from req0, req1, last_grant).
- The FSM, counters and datapath mux stay in serial_link_sched.

Test Plan:
- Single burst: req0, len0=1, data stream 0x11 then 0x22, char_sent model 10 cycles after each ser_load.
  - Required: ser_data sequence 0xA1, 0x11, 0x22.
  - Exactly 2 read_inc0 pulses, one done0, busy low afterwards.
- Maximum burst: req1, len1=15.
  - Required: header 0xBF, then 16 payload loads, 16 read_inc1 pulses, one done1.
  - remaining does not wrap.
- Tie after reset: req0 and req1 both high at the same cycle, both held through the first done.
  - Required: channel 0 served first (header 0xA?), then channel 1 (header 0xB?).
  - With both re-requested continuously, grants alternate 0,1,0,1.
- Timeout: TIMEOUT_CYC=50, char_sent never asserted.
  - Required: ERR reached 50 cycles after ser_load, timeout_err=1.
  - No read_inc or done pulses; next request is still served.
  - clear_err drops timeout_err.
- Reset mid-burst: assert rst=0 during DAT_WAIT of the 2nd byte of a 4-byte burst.
  - Required: all outputs 0 immediately and no done.
  - After release, a fresh tie grants channel 0.
- Stray events:
  - char_sent pulsed while IDLE or during POP → no state change.
  - req0 dropped mid-burst → burst still completes for the full latched length.

Source files
------------

// File: rtl/serial_link_sched_pkg.sv
// serial_link_sched shared types and helpers.
// Burst header layout, FSM states and default widths.
package serial_link_sched_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;

  localparam logic [2:0] HDR_SYNC = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LOAD,
    HDR_WAIT,
    DAT_LOAD,
    DAT_WAIT,
    POP,
    DONE,
    ERR
  } state_t;

  function automatic logic [DATA_W_DEF-1:0] mk_hdr(
    input logic                 g,
    input logic [LEN_W_DEF-1:0] len
  );
    return {HDR_SYNC, g, len};
  endfunction

endpackage

// File: rtl/serial_link_sched_rr_arb2.sv
// Two-way round-robin pick for serial_link_sched.
// Ties go to the channel that was not served last.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic pick
);

  always_comb begin
    valid = req0 | req1;
    pick  = 1'b0;
    unique case (1'b1)
      (req0 & req1):  pick = ~last_grant;
      (req1 & ~req0): pick = 1'b1;
      default:        pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_link_sched.sv
// Burst scheduler draining two buffer channels onto serial_out.
// Frames each burst as a header byte plus len+1 payload bytes.
module serial_link_sched
  import serial_link_sched_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LEN_W       = LEN_W_DEF,
  parameter int TO_W        = 20,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              read_inc0,
  output logic              read_inc1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] ser_data,
  output logic              ser_load,
  output logic              ser_trans_en,
  input  logic              char_sent,
  output logic              busy,
  output logic              grant,
  output logic              timeout_err,
  input  logic              clear_err
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC - 1);

  state_t            state;
  logic              last_grant;
  logic [LEN_W-1:0]  rem;
  logic [TO_W-1:0]   cnt;
  logic [TO_W-1:0]   cnt_nxt;
  logic [DATA_W-1:0] ser_q;
  logic [DATA_W-1:0] data_sel;
  logic [LEN_W-1:0]  len_sel;
  logic              arb_valid;
  logic              arb_pick;

  rr_arb2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .valid      (arb_valid),
    .pick       (arb_pick)
  );

  assign cnt_nxt  = cnt + TO_W'(1);
  assign len_sel  = arb_pick ? len1 : len0;
  assign data_sel = grant ? data1 : data0;

  // Buffer head only settles the cycle after the pop, so payload is passed through live.
  assign ser_data = (state == DAT_LOAD) ? data_sel : ser_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant        <= 1'b0;
      rem          <= '0;
      cnt          <= '0;
      ser_q        <= '0;
      ser_load     <= 1'b0;
      ser_trans_en <= 1'b0;
      read_inc0    <= 1'b0;
      read_inc1    <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      ser_load  <= 1'b0;
      read_inc0 <= 1'b0;
      read_inc1 <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      if (clear_err)
        timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            grant        <= arb_pick;
            rem          <= len_sel;
            ser_q        <= DATA_W'(mk_hdr(arb_pick, len_sel));
            ser_load     <= 1'b1;
            ser_trans_en <= 1'b1;
            busy         <= 1'b1;
            cnt          <= '0;
            state        <= HDR_LOAD;
          end
        end
        HDR_LOAD: state <= HDR_WAIT;
        DAT_LOAD: begin
          ser_q <= data_sel;
          state <= DAT_WAIT;
        end
        HDR_WAIT, DAT_WAIT: begin
          if (char_sent) begin
            cnt <= '0;
            if (state == HDR_WAIT) begin
              ser_load <= 1'b1;
              state    <= DAT_LOAD;
            end else begin
              ser_trans_en <= 1'b0;
              read_inc0    <= ~grant;
              read_inc1    <= grant;
              state        <= POP;
            end
          end else if (cnt_nxt == TO_LIM) begin
            ser_trans_en <= 1'b0;
            timeout_err  <= 1'b1;
            state        <= ERR;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        POP: begin
          if (rem == '0) begin
            done0 <= ~grant;
            done1 <= grant;
            state <= DONE;
          end else begin
            rem          <= rem - LEN_W'(1);
            cnt          <= '0;
            ser_load     <= 1'b1;
            ser_trans_en <= 1'b1;
            state        <= DAT_LOAD;
          end
        end
        DONE: begin
          last_grant <= grant;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_link_sched.sv
// Directed self-checking bench for serial_link_sched.
// Buffer and serial_out are modelled by small negedge processes.
module tb_serial_link_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [3:0] len0 = '0;
  logic [3:0] len1 = '0;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       read_inc0;
  logic       read_inc1;
  logic       done0;
  logic       done1;
  logic [7:0] ser_data;
  logic       ser_load;
  logic       ser_trans_en;
  logic       char_sent;
  logic       busy;
  logic       grant;
  logic       timeout_err;
  logic       clear_err = 1'b0;

  logic       cs_auto = 1'b0;
  logic       cs_manual = 1'b0;
  logic       auto_cs = 1'b1;
  int         cs_cnt = 0;

  logic [7:0] buf0 [64];
  logic [7:0] buf1 [64];
  int         idx0 = 0;
  int         idx1 = 0;
  logic [7:0] ld [$];
  int         n_ri0 = 0;
  int         n_ri1 = 0;
  int         n_d0 = 0;
  int         n_d1 = 0;
  int         cyc = 0;

  int         n_cmp = 0;
  int         n_err = 0;
  bit         ok;
  bit         all_ok;
  bit         pay_ok;
  logic [3:0] ord;
  int         t_load;
  int         t_err;
  int         r0;
  int         d0;

  assign data0     = buf0[idx0];
  assign data1     = buf1[idx1];
  assign char_sent = cs_auto | cs_manual;

  serial_link_sched #(
    .TIMEOUT_CYC (50)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .req1         (req1),
    .len0         (len0),
    .len1         (len1),
    .data0        (data0),
    .data1        (data1),
    .read_inc0    (read_inc0),
    .read_inc1    (read_inc1),
    .done0        (done0),
    .done1        (done1),
    .ser_data     (ser_data),
    .ser_load     (ser_load),
    .ser_trans_en (ser_trans_en),
    .char_sent    (char_sent),
    .busy         (busy),
    .grant        (grant),
    .timeout_err  (timeout_err),
    .clear_err    (clear_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ser_load) ld.push_back(ser_data);
    if (read_inc0) begin n_ri0++; idx0++; end
    if (read_inc1) begin n_ri1++; idx1++; end
    if (done0) n_d0++;
    if (done1) n_d1++;
  end

  // serial_out model: char_sent 10 cycles after each load
  always @(negedge clk) begin
    cs_auto = 1'b0;
    if (cs_cnt > 0) begin
      cs_cnt--;
      if (cs_cnt == 0) cs_auto = 1'b1;
    end
    if (ser_load && auto_cs) cs_cnt = 10;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sig(input int which, input int budget,
                          output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (which)
        0:       found = done0;
        1:       found = done1;
        2:       found = ser_load;
        3:       found = read_inc0;
        4:       found = timeout_err;
        default: found = done0 | done1;
      endcase
      if (found) break;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      buf0[i] = 8'h40 + 8'(i);
      buf1[i] = 8'hC0 + 8'(i);
    end
    buf0[0] = 8'h11;
    buf0[1] = 8'h22;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_strobes",
        {ser_load, ser_trans_en, read_inc0, read_inc1, done0, done1}, 0);
    chk("rst_data", ser_data, 0);
    rst = 1'b1;
    @(negedge clk);

    // single burst with stray char_sent in POP and IDLE
    ld.delete();
    len0 = 4'd1;
    req0 = 1'b1;
    @(negedge clk);
    chk("t1_lat_load", ser_load, 1);
    chk("t1_hdr", ser_data, 8'hA1);
    wait_sig(3, 100, ok);
    chk("t1_pop_seen", ok, 1);
    cs_manual = 1'b1;
    @(negedge clk);
    cs_manual = 1'b0;
    wait_sig(0, 200, ok);
    req0 = 1'b0;
    chk("t1_done", ok, 1);
    @(negedge clk);
    chk("t1_idle", busy, 0);
    cs_manual = 1'b1;
    @(negedge clk);
    cs_manual = 1'b0;
    chk("t1_stray_idle", {busy, ser_load}, 0);
    #1;
    chk("t1_nbytes", ld.size(), 3);
    chk("t1_seq", {ld[0], ld[1], ld[2]}, 24'hA11122);
    chk("t1_ri0", n_ri0, 2);
    chk("t1_done0", n_d0, 1);

    // maximum burst on channel 1
    ld.delete();
    len1 = 4'd15;
    req1 = 1'b1;
    wait_sig(1, 600, ok);
    req1 = 1'b0;
    chk("t2_done", ok, 1);
    #1;
    chk("t2_nbytes", ld.size(), 17);
    chk("t2_hdr", ld[0], 8'hBF);
    pay_ok = 1'b1;
    for (int i = 0; i < 16; i++)
      if (ld[i+1] !== 8'hC0 + 8'(i)) pay_ok = 1'b0;
    chk("t2_payload", pay_ok, 1);
    chk("t2_ri1", n_ri1, 16);
    chk("t2_done1", n_d1, 1);

    // tie after reset, then alternation
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ld.delete();
    len0 = 4'd0;
    len1 = 4'd0;
    req0 = 1'b1;
    req1 = 1'b1;
    all_ok = 1'b1;
    ord = '0;
    for (int k = 0; k < 4; k++) begin
      wait_sig(5, 100, ok);
      if (!ok) all_ok = 1'b0;
      ord[3-k] = done1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("t3_all_done", all_ok, 1);
    chk("t3_order", ord, 4'b0101);
    #1;
    chk("t3_hdr0", ld[0], 8'hA0);
    chk("t3_hdr1", ld[2], 8'hB0);

    // timeout with no char_sent
    @(negedge clk);
    auto_cs = 1'b0;
    r0 = n_ri0;
    d0 = n_d0;
    len0 = 4'd0;
    req0 = 1'b1;
    wait_sig(2, 5, ok);
    t_load = cyc;
    wait_sig(4, 100, ok);
    t_err = cyc;
    req0 = 1'b0;
    chk("t4_err_seen", ok, 1);
    chk("t4_latency", t_err - t_load, 50);
    chk("t4_err_state", {busy, ser_trans_en}, 2'b10);
    @(negedge clk);
    #1;
    chk("t4_no_pop", n_ri0 - r0, 0);
    chk("t4_no_done", n_d0 - d0, 0);
    auto_cs = 1'b1;
    len1 = 4'd0;
    req1 = 1'b1;
    wait_sig(1, 100, ok);
    req1 = 1'b0;
    chk("t4_served", ok, 1);
    chk("t4_sticky", timeout_err, 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("t4_clear", timeout_err, 0);

    // set wins over a held clear
    auto_cs = 1'b0;
    clear_err = 1'b1;
    req0 = 1'b1;
    wait_sig(2, 5, ok);
    repeat (50) @(negedge clk);
    chk("t4b_set_wins", timeout_err, 1);
    req0 = 1'b0;
    @(negedge clk);
    chk("t4b_cleared", timeout_err, 0);
    clear_err = 1'b0;

    // char_sent on the limit cycle is a success
    @(negedge clk);
    len0 = 4'd0;
    req0 = 1'b1;
    wait_sig(2, 5, ok);
    repeat (49) @(negedge clk);
    cs_manual = 1'b1;
    @(negedge clk);
    cs_manual = 1'b0;
    chk("t5_edge_ok", {ser_load, timeout_err}, 2'b10);
    repeat (2) @(negedge clk);
    cs_manual = 1'b1;
    @(negedge clk);
    cs_manual = 1'b0;
    wait_sig(0, 10, ok);
    req0 = 1'b0;
    chk("t5_done", ok, 1);

    // reset during the second payload byte
    @(negedge clk);
    auto_cs = 1'b1;
    len0 = 4'd3;
    req0 = 1'b1;
    all_ok = 1'b1;
    wait_sig(2, 5, ok);
    if (!ok) all_ok = 1'b0;
    wait_sig(2, 30, ok);
    if (!ok) all_ok = 1'b0;
    wait_sig(2, 30, ok);
    if (!ok) all_ok = 1'b0;
    chk("t6_reached", all_ok, 1);
    @(negedge clk);
    #1;
    d0 = n_d0;
    rst = 1'b0;
    #1;
    chk("t6_rst_out",
        {ser_load, ser_trans_en, busy, read_inc0, read_inc1,
         done0, done1, grant, timeout_err}, 0);
    chk("t6_rst_data", ser_data, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("t6_no_done", n_d0 - d0, 0);
    req0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    len0 = 4'd0;
    len1 = 4'd0;
    req0 = 1'b1;
    req1 = 1'b1;
    wait_sig(2, 5, ok);
    chk("t6_tie_hdr", ser_data, 8'hA0);
    wait_sig(0, 100, ok);
    req0 = 1'b0;
    req1 = 1'b0;
    chk("t6_tie_done", ok, 1);

    // req and len dropped after grant
    @(negedge clk);
    ld.delete();
    r0 = n_ri0;
    len0 = 4'd2;
    req0 = 1'b1;
    wait_sig(2, 5, ok);
    req0 = 1'b0;
    len0 = 4'd0;
    wait_sig(0, 200, ok);
    chk("t7_done", ok, 1);
    #1;
    chk("t7_nbytes", ld.size(), 4);
    chk("t7_hdr", ld[0], 8'hA2);
    chk("t7_pops", n_ri0 - r0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
